serial_subtractor_4bit: RTL and testbench
=========================================

Name: serial_subtractor_4bit

Overview:
Bit-serial two's-complement subtractor, the subtract-direction counterpart of the team's structural 4-bit ripple adder. It computes diff = a - b as a + ~b + 1 through one full-adder cell. The cell processes one bit per clock, LSB first, and reports carryout and signed overflow with the same meanings as the adder. It is a small-area arithmetic unit for sequenced datapaths, driven by a start/busy/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, two's complement
b  input  WIDTH  subtrahend, two's complement
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results become valid
diff  output  WIDTH  a - b, two's complement
carryout  output  1  carry out of MSB (1 = no borrow, unsigned a >= b)
overflow  output  1  signed overflow: carry-into-MSB XOR carryout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, async on rst_n low:
  - state=IDLE.
  - busy=0, done=0, diff=0, carryout=0, overflow=0.
  - Internal shift registers, bit counter and carry cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a into A_sh and ~b into B_sh, sets carry=1, count=0, and moves to RUN.
  - start=0 holds. a and b are don't-care outside the start cycle.
- RUN, each cycle:
  - s = A_sh[0]^B_sh[0]^carry.
  - c = majority(A_sh[0], B_sh[0], carry).
  - s shifts into the MSB of the result register; A_sh and B_sh shift right.
  - carry<=c; count++.
  - On count==WIDTH-2, the incoming carry is stored as cin_msb.
  - On count==WIDTH-1, the next state is DONE.
- DONE, exactly one cycle:
  - done=1; diff, carryout=carry and overflow=cin_msb^carry are registered to outputs.
  - Next state is IDLE.
- Latency: start sampled at edge T, busy high for edges T+1..T+WIDTH, done high for the cycle after edge T+WIDTH+1. Results are valid when done is high.
- Outputs hold their last result until the next DONE or reset. They do not change during a subsequent RUN.
- busy=1 only in RUN. done and busy are never high together.
- start while in RUN or DONE is ignored, not queued. start high in the same cycle done is high is also ignored; start is re-sampled next cycle in IDLE.
- Reset mid-RUN aborts the operation. All outputs go to their reset values immediately; no done pulse.
- Wrap-around is modulo 2^WIDTH; no width extension.
- Special cases a==b and b==0 need no special handling: 0 - 0 yields diff=0, carryout=1, overflow=0.

Optional Feature:
SERIAL_SUB_SATURATE_EN
- Defined: when overflow=1, diff is clamped to the signed limit in the DONE cycle. If a is non-negative (a[MSB]=0), the limit is max positive (0111 for WIDTH=4); if a is negative, it is min negative (1000 for WIDTH=4). carryout and overflow are reported unchanged, so overflow still flags the clamp.
- Undefined: diff is always the raw modular result. No extra logic is instantiated.

Test Plan:
- Reset, then a=0110, b=0010, start for 1 cycle -> busy for 4 cycles, done on the 6th edge after start; diff=0100, carryout=1, overflow=0.
- a=0010, b=0110 -> diff=1100, carryout=0 (borrow), overflow=0.
- a=0111, b=1111 (7-(-1)) -> diff=1000, carryout=0, overflow=1. With SERIAL_SUB_SATURATE_EN: diff=0111, overflow=1.
- a=1000, b=0001 (-8-1) -> diff=0111, carryout=1, overflow=1. With SERIAL_SUB_SATURATE_EN: diff=1000.
- Start a=0101, b=0011; pulse start again with a=1111, b=1111 while busy -> second request ignored; done once, diff=0010, carryout=1, overflow=0.
- Start a=0110, b=0010; assert rst_n=0 two cycles into RUN -> busy, done, diff, carryout, overflow all 0 immediately. After release: IDLE, no done pulse until a new start.

Source files
------------

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
//   Bit-serial two's-complement subtractor. It computes diff = a - b as
//   a + ~b + 1 through one full-adder cell, one bit per clock, LSB first.
//   Optional macro SERIAL_SUB_SATURATE_EN clamps diff to the signed limit
//   when overflow is flagged. When the macro is undefined, diff is the raw
//   modular result.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only in IDLE (ignored while done is high)
//   a, b      in   WIDTH-bit operands, latched on the accepted start
//   busy      out  high while the serial loop runs
//   done      out  one-cycle pulse when diff/carryout/overflow update
//   diff      out  a - b, modulo 2^WIDTH
//   carryout  out  carry out of MSB (1 = no borrow)
//   overflow  out  signed overflow (carry into MSB ^ carry out of MSB)
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    count;
    logic             carry, cin_msb;
    logic             s, c;
    logic             start_ok;
    logic             ovf;
    logic [WIDTH-1:0] diff_fin;

    // The done pulse is visible while the FSM is already back in IDLE, so a
    // start in that cycle has to be masked.
    assign start_ok = start && !done;

    // Full-adder cell
    assign s = a_sh[0] ^ b_sh[0] ^ carry;
    assign c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    assign busy = (state == S_RUN);
    assign ovf  = cin_msb ^ carry;

`ifdef SERIAL_SUB_SATURATE_EN
    // On overflow the result sign is always opposite to the sign of a.
    // A negative raw result therefore means a was non-negative, and the
    // clamp goes to max positive.
    always_comb begin
        diff_fin = r_sh;
        if (ovf)
            diff_fin = r_sh[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign diff_fin = r_sh;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN:   if (count == CW'(WIDTH - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            count    <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        a_sh  <= a;
                        b_sh  <= ~b;
                        carry <= 1'b1;   // +1 of the two's-complement negate
                        count <= '0;
                    end
                end
                S_RUN: begin
                    r_sh  <= {s, r_sh[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c;
                    count <= count + CW'(1);
                    // The carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (count == CW'(WIDTH - 2)) cin_msb <= c;
                end
                S_DONE: begin
                    done     <= 1'b1;
                    diff     <= diff_fin;
                    carryout <= carry;
                    overflow <= ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
module tb_serial_subtractor_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, carryout, overflow;
    logic [W-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .carryout(carryout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic
    typedef struct packed { logic [W-1:0] d; logic co; logic ov; } res_t;

    function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        int sx, sy, sr;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sr = sx - sy;
        r.d  = W'(int'(x) - int'(y));
        r.co = (x >= y);
        r.ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
`ifdef SERIAL_SUB_SATURATE_EN
        if (r.ov) r.d = (sx >= 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
`endif
        return r;
    endfunction

    // Timing model: ph 0 = idle, 1..W = busy cycles, W+1 = result cycle,
    // done pulses on the cycle after that.
    int           ph = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] ma = '0, mb = '0;
    res_t         exp_r = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; m_done <= 1'b0; exp_r <= '0;
        end else begin
            m_done <= 1'b0;
            if (ph == 0) begin
                if (start && !m_done) begin ph <= 1; ma <= a; mb <= b; end
            end else if (ph <= W) begin
                ph <= ph + 1;
            end else begin
                ph <= 0; m_done <= 1'b1; exp_r <= ref_sub(ma, mb);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(ph >= 1 && ph <= W));
            chk("done", int'(done), int'(m_done));
            chk("diff", int'(diff), int'(exp_r.d));
            chk("carryout", int'(carryout), int'(exp_r.co));
            chk("overflow", int'(overflow), int'(exp_r.ov));
        end
    end

    task automatic wait_done(output int cyc, output bit got);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int ed, input int eco, input int eov, input string nm);
        int cyc; bit got;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        wait_done(cyc, got);
        chk({nm, "_latency"}, cyc, W + 2);
        chk({nm, "_diff"}, int'(diff), ed);
        chk({nm, "_co"}, int'(carryout), eco);
        chk({nm, "_ov"}, int'(overflow), eov);
    endtask

    initial begin
        int cyc, ndone; bit got;
        #2 rst_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0110, 4'b0010, 4'b0100, 1, 0, "6m2");
        run_op(4'b0010, 4'b0110, 4'b1100, 0, 0, "2m6");
`ifdef SERIAL_SUB_SATURATE_EN
        run_op(4'b0111, 4'b1111, 4'b0111, 0, 1, "7mm1");
        run_op(4'b1000, 4'b0001, 4'b1000, 1, 1, "m8m1");
`else
        run_op(4'b0111, 4'b1111, 4'b1000, 0, 1, "7mm1");
        run_op(4'b1000, 4'b0001, 4'b0111, 1, 1, "m8m1");
`endif
        run_op(4'b0000, 4'b0000, 4'b0000, 1, 0, "0m0");
        run_op(4'b1010, 4'b1010, 4'b0000, 1, 0, "aeqb");

        // Second start while busy must be ignored
        @(negedge clk); a = 4'b0101; b = 4'b0011; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 4'b1111; b = 4'b1111; start = 1'b1;
        wait_done(cyc, got);
        chk("ign_diff", int'(diff), 4'b0010);
        chk("ign_co", int'(carryout), 1);
        chk("ign_ov", int'(overflow), 0);
        ndone = 0;
        repeat (8) begin @(negedge clk); if (done) ndone++; end
        chk("ign_extra_done", ndone, 0);

        // Reset two cycles into RUN aborts the operation
        @(negedge clk); a = 4'b0110; b = 4'b0010; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_co", int'(carryout), 0);
        chk("abort_ov", int'(overflow), 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin @(negedge clk); if (done || busy) ndone++; end
        chk("abort_quiet", ndone, 0);

        // Random traffic, including start held through done cycles
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            start = (i % 200 < 40) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
